// File: rtl/vscale_wb_stage.sv
// Writeback stage: registers the EX result, waits out load responses, extracts load data
// and drives the register-file write port and WB bypass. VSCALE_WB_MISALIGN_CHECK_EN adds wb_misaligned.
module vscale_wb_stage #(
  parameter int unsigned XPR_LEN        = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_kill,
  input  logic [XPR_LEN-1:0]        ex_alu_out,
  input  logic                      ex_wr_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_is_load,
  input  logic [2:0]                ex_mem_type,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_wait,
  output logic                      stall_wb,
  output logic                      wb_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [XPR_LEN-1:0]        wb_wdata,
  output logic                      wb_bypass_valid,
`ifdef VSCALE_WB_MISALIGN_CHECK_EN
  output logic                      wb_misaligned,
`endif
  output logic [REG_ADDR_WIDTH-1:0] wb_rd
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ALU       = 2'd1;
  localparam logic [1:0] LOAD_WAIT = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      wr_reg_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [XPR_LEN-1:0]        alu_q;
  logic [2:0]                mem_type_q;

  logic                      wb_valid;
  logic                      wb_is_load;
  logic                      misaligned;
  logic [1:0]                offset;
  logic [7:0]                byte_val;
  logic [15:0]               half_val;
  logic [XPR_LEN-1:0]        load_data;

  assign wb_valid   = (state_q != IDLE);
  assign wb_is_load = (state_q == LOAD_WAIT);
  assign offset     = alu_q[1:0];

`ifdef VSCALE_WB_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (wb_is_load) begin
      unique case (mem_type_q[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = offset[0];
        default: misaligned = (offset != 2'b00);
      endcase
    end
  end
  assign wb_misaligned = misaligned;
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned load retires immediately instead of waiting on memory.
  assign stall_wb = wb_valid & wb_is_load & dmem_wait & ~misaligned;

  always_comb begin
    state_d = IDLE;
    if (ex_valid && !ex_kill) begin
      state_d = ex_is_load ? LOAD_WAIT : ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_reg_q   <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      mem_type_q <= 3'b000;
    end else if (!stall_wb) begin
      state_q    <= state_d;
      wr_reg_q   <= ex_wr_reg;
      rd_q       <= ex_rd;
      alu_q      <= ex_alu_out;
      mem_type_q <= ex_mem_type;
    end
  end

  always_comb begin
    unique case (offset)
      2'd0:    byte_val = dmem_rdata[7:0];
      2'd1:    byte_val = dmem_rdata[15:8];
      2'd2:    byte_val = dmem_rdata[23:16];
      default: byte_val = dmem_rdata[31:24];
    endcase
    half_val = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    // mem_type_q[2] selects zero extension.
    unique case (mem_type_q[1:0])
      2'b00:   load_data = {{(XPR_LEN-8){~mem_type_q[2] & byte_val[7]}}, byte_val};
      2'b01:   load_data = {{(XPR_LEN-16){~mem_type_q[2] & half_val[15]}}, half_val};
      default: load_data = XPR_LEN'(dmem_rdata);
    endcase
  end

  assign wb_wdata        = wb_is_load ? load_data : alu_q;
  assign wb_bypass_valid = wb_valid & wr_reg_q & ~stall_wb & ~misaligned;
  assign wb_wen          = wb_bypass_valid & (rd_q != '0);
  assign wb_waddr        = rd_q;
  assign wb_rd           = rd_q;

endmodule
